// File: rtl/seq_div_pkg.sv
// ============================================================================
// Module : seq_div_pkg
// Brief  : Shared state encoding, default width and counter sizing for seq_div_16x8.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DW_DEF = 8;

  // Counter must hold the value 2*DW itself, hence the +1.
  function automatic int cnt_w(input int dw);
    return $clog2(2 * dw + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_div_16x8_div_step.sv
// ============================================================================
// Module : div_step
// Brief  : One combinational restoring-division iteration (shift, trial subtract, restore).
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module div_step #(
  parameter int DW = 8
) (
  input  logic [DW:0]   i_rem,
  input  logic          i_bit,
  input  logic [DW-1:0] i_divisor,
  output logic [DW:0]   o_rem,
  output logic          o_q
);

  logic [DW+1:0] w_shift;
  logic [DW:0]   w_diff;
  logic          w_ge;

  assign w_shift = {i_rem, i_bit};
  // The full-width compare decides the sign; the truncated difference is exact whenever it is used.
  assign w_ge    = (w_shift >= {2'b00, i_divisor});
  assign w_diff  = w_shift[DW:0] - {1'b0, i_divisor};
  assign o_rem   = w_ge ? w_diff : w_shift[DW:0];
  assign o_q     = w_ge;

endmodule

`default_nettype wire

// File: rtl/seq_div_16x8.sv
// ============================================================================
// Module : seq_div_16x8
// Brief  : Sequential restoring divider, 2*DW-bit dividend by DW-bit divisor, valid/ready I/O.
//          Optional macro SEQ_DIV_ZERO_FLAG_EN adds div_zero and a fast divide-by-zero path.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module seq_div_16x8
  import seq_div_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] quotient,
  output logic [DW-1:0]   remainder
`ifdef SEQ_DIV_ZERO_FLAG_EN
  ,
  output logic            div_zero
`endif
);

  localparam int            CW      = cnt_w(DW);
  localparam logic [CW-1:0] c_NITER = CW'(2 * DW);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2*DW-1:0] r_quo;
  logic [DW:0]     r_rem;
  logic [DW-1:0]   r_div;
  logic [CW-1:0]   r_cnt;
  logic            r_dz;
  logic [DW:0]     w_rem_nxt;
  logic            w_qbit;
  logic            w_zero_in;

  assign w_zero_in = (divisor == '0);

  div_step #(.DW(DW)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_quo[2*DW-1]),
    .i_divisor (r_div),
    .o_rem     (w_rem_nxt),
    .o_q       (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef SEQ_DIV_ZERO_FLAG_EN
          w_state_nxt = w_zero_in ? DONE : RUN;
`else
          w_state_nxt = RUN;
`endif
        end
      end
      RUN: begin
        if (r_cnt == CW'(1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_quo     <= '0;
      r_rem     <= '0;
      r_div     <= '0;
      r_cnt     <= '0;
      r_dz      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef SEQ_DIV_ZERO_FLAG_EN
      div_zero  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_quo <= dividend;
            r_rem <= '0;
            r_div <= divisor;
            r_cnt <= c_NITER;
            r_dz  <= w_zero_in;
`ifdef SEQ_DIV_ZERO_FLAG_EN
            if (w_zero_in) begin
              r_cnt     <= '0;
              quotient  <= '1;
              remainder <= dividend[DW-1:0];
              div_zero  <= 1'b1;
            end
`endif
          end
        end
        RUN: begin
          r_quo <= {r_quo[2*DW-2:0], w_qbit};
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            // With a zero divisor the partial remainder is just the dividend's low bits.
            quotient  <= r_dz ? '1 : {r_quo[2*DW-2:0], w_qbit};
            remainder <= w_rem_nxt[DW-1:0];
`ifdef SEQ_DIV_ZERO_FLAG_EN
            div_zero  <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_div_16x8.sv
// ============================================================================
// Module : tb_seq_div_16x8
// Brief  : Scoreboard bench for seq_div_16x8 with directed vectors; honours SEQ_DIV_ZERO_FLAG_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_seq_div_16x8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] quotient;
  logic [7:0]  remainder;
`ifdef SEQ_DIV_ZERO_FLAG_EN
  logic        div_zero;
`endif

  seq_div_16x8 #(.DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef SEQ_DIV_ZERO_FLAG_EN
    ,
    .div_zero  (div_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(quotient), 32'hDEAD);
      end else begin
        m_e = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(m_e.q));
        chk("remainder", 32'(remainder), 32'(m_e.r));
`ifdef SEQ_DIV_ZERO_FLAG_EN
        chk("div_zero", 32'(div_zero), 32'(m_e.dz));
`endif
      end
    end
  end

  task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                       input logic [15:0] eq, input logic [7:0] er, input string nm);
    exp_t e;
    int   n;
    int   lat;
    lat = 16;
`ifdef SEQ_DIV_ZERO_FLAG_EN
    if (b == 8'd0) lat = 0;
`endif
    e.q = eq; e.r = er; e.dz = (b == 8'd0);
    @(posedge clk); #1;
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; dividend = a; divisor = b;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 16'($urandom); divisor = 8'($urandom);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(lat));
    if (out_ready) begin
      @(posedge clk); #1;
      chk({nm, "_back_idle"}, 32'({in_ready, out_valid}), 32'b10);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    rst_n = 1'b1;

    do_op(16'd65025, 8'd255, 16'd255,   8'd0, "sq255");
    do_op(16'd100,   8'd7,   16'd14,    8'd2, "d100_7");
    do_op(16'd65535, 8'd1,   16'd65535, 8'd0, "max_1");
    // Multiplier round trips: x*y / y == x
    do_op(16'd15, 8'd3, 16'd5, 8'd0, "rt5_3");
    do_op(16'd8,  8'd2, 16'd4, 8'd0, "rt4_2");
    do_op(16'd4,  8'd2, 16'd2, 8'd0, "rt2_2");
    do_op(16'd48, 8'd8, 16'd6, 8'd0, "rt6_8");
    do_op(16'h04D2, 8'd0, 16'hFFFF, 8'hD2, "div0");

    out_ready = 1'b0;
    do_op(16'd1000, 8'd33, 16'd30, 8'd10, "bp");
    for (int i = 0; i < 10; i++) begin
      chk("bp_q_stable", 32'(quotient), 32'd30);
      chk("bp_r_stable", 32'(remainder), 32'd10);
      chk("bp_hold", 32'({in_ready, out_valid}), 32'b01);
      in_valid = 1'b1; dividend = 16'h1111; divisor = 8'd3;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 32'({in_ready, out_valid}), 32'b10);

    in_valid = 1'b1; dividend = 16'd500; divisor = 8'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_state", 32'({in_ready, out_valid}), 32'b10);
    chk("mid_rst_q", 32'(quotient), 32'd0);
    chk("mid_rst_r", 32'(remainder), 32'd0);
    rst_n = 1'b1;
    do_op(16'd500, 8'd9, 16'd55, 8'd5, "d500_9");

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_div_16x8.md
Name: seq_div_16x8

Overview:
- Sequential restoring divider: the inverse operation of the 8x8 array multiplier.
- Takes a 2*DW-bit dividend (a multiplier product) and a DW-bit divisor.
- Returns a 2*DW-bit quotient and a DW-bit remainder after 2*DW iterations.
- Sits downstream of the multiplier for product check-back and scaling paths.
- Uses a valid/ready handshake on both input and output.

Parameters:
- DW, 8, divisor and remainder width; dividend and quotient width is 2*DW.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- in_valid  input  1  dividend/divisor present
- in_ready  output  1  block can accept an operation
- dividend  input  2*DW  numerator, unsigned
- divisor  input  DW  denominator, unsigned
- out_valid  output  1  quotient/remainder valid
- out_ready  input  1  consumer accepts the result
- quotient  output  2*DW  unsigned floor(dividend/divisor)
- remainder  output  DW  dividend mod divisor

Behaviour:
- Reset: rst_n low at an edge gives state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, counter=0.
  - Reset dominates every other event, including a mid-RUN operation. That operation is discarded with no output.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. When in_valid&&in_ready at an edge (E0): latch divisor, load the shift register with the dividend, clear the partial remainder (DW+1 bits), set counter=2*DW, go to RUN.
  - RUN: in_ready=0. Each edge does one restoring step:
    - shift {rem,quo} left by 1, bringing the dividend MSB into rem.
    - trial = rem - {1'b0,divisor}.
    - if trial >= 0: rem = trial and the new quotient LSB = 1; otherwise the LSB = 0.
    - decrement the counter. The step that takes the counter to 0 also moves the FSM to DONE.
  - DONE: entered at edge E0+2*DW. out_valid=1; quotient and remainder are registered and held stable.
    - out_ready high at an edge: go to IDLE, out_valid=0 next cycle.
    - out_ready low: hold indefinitely.
- Latency: out_valid is first high in the cycle after edge E0+2*DW.
  - Minimum spacing between accepts is 2*DW+2 cycles. There is no overlap of operations.
- in_valid while not in IDLE is ignored, not queued.
- Inputs are sampled only at the accept edge. Later changes to dividend/divisor have no effect.
- Divide by zero (divisor==0):
  - quotient = all ones (2^(2*DW)-1), remainder = dividend[DW-1:0].
  - Latency is the normal 2*DW cycles unless the optional feature is enabled.
  - The remainder register never overflows, because the internal rem is DW+1 bits and the special case overrides the result.
- Arithmetic is unsigned throughout. The quotient is full width, so the quotient cannot overflow for any input.

Optional Feature:
- Macro SEQ_DIV_ZERO_FLAG_EN.
- Defined:
  - Adds output port div_zero (1 bit), reset 0, valid only while out_valid=1.
  - A zero divisor at accept goes IDLE to DONE directly, so out_valid is high the cycle after E0, with div_zero=1 and the same quotient/remainder values as above.
  - div_zero=0 for all nonzero divisors.
- Undefined: no div_zero port; divide by zero takes the full 2*DW cycles and yields the values above.

Decomposition:
- Package seq_div_pkg holds:
  - the state enum (IDLE, RUN, DONE), with encodings 2'b00, 2'b01, 2'b10.
  - the default width constant DW_DEF=8.
  - the counter width function clog2(2*DW+1).
- One sub-module, div_step: purely combinational single restoring iteration. It takes rem, the shift-in bit and the divisor, and returns the next rem and the quotient bit. The top instantiates it once; the FSM, counter and handshake registers live in the top.

Test Plan:
- dividend=65025, divisor=255 -> quotient=255, remainder=0. out_valid rises exactly 16 edges after accept.
- dividend=100, divisor=7 -> quotient=14, remainder=2. dividend=65535, divisor=1 -> quotient=65535, remainder=0.
- Round trip: for x,y in {(5,3),(4,2),(2,2),(6,8)}, feed the multiplier product x*y with divisor y -> quotient=x, remainder=0.
- dividend=1234 (0x04D2), divisor=0 -> quotient=0xFFFF, remainder=0xD2.
  - With SEQ_DIV_ZERO_FLAG_EN: div_zero=1 and out_valid the cycle after accept.
  - Without: out_valid at 16 edges.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> in_ready=1 on the next cycle.
- Reset mid-op: accept 500/9, pull rst_n low at iteration 7 -> next cycle IDLE, out_valid=0, outputs 0. Then 500/9 completes -> quotient=55, remainder=5.
